// File: rtl/cal_field_counter_if.sv
// Bus bundle for cal_field_counter: key/chain/load inputs and the registered field outputs.
interface cal_field_counter_if #(
  parameter int WIDTH = 6
);
  logic             manual_set;
  logic             up;
  logic             down;
  logic             carry_in;
  logic             borrow_in;
  logic [WIDTH-1:0] dyn_max;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] value;
  logic             carry_out;
  logic             borrow_out;
  logic             at_max;

  modport master (
    output manual_set, up, down, carry_in, borrow_in, dyn_max, load, load_val,
    input  value, carry_out, borrow_out, at_max
  );

  modport slave (
    input  manual_set, up, down, carry_in, borrow_in, dyn_max, load, load_val,
    output value, carry_out, borrow_out, at_max
  );
endinterface

// File: rtl/cal_field_counter.sv
// Generic calendar/time field counter with runtime ceiling, chained carry/borrow and manual adjust.
// Optional key auto-repeat is built when AUTOREPEAT_EN is defined.
module cal_field_counter #(
  parameter int WIDTH      = 6,
  parameter int MIN_VAL    = 1,
  parameter int MAX_VAL    = 31,
  parameter int RESET_VAL  = 1,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  cal_field_counter_if.slave bus
);
  localparam int W1 = WIDTH + 1;
  localparam logic [WIDTH:0]   MINV = W1'(MIN_VAL);
  localparam logic [WIDTH:0]   MAXV = W1'(MAX_VAL);
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

  if (MIN_VAL > MAX_VAL || RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL ||
      REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_chk
    $error("cal_field_counter: inconsistent parameters");
  end

  logic [WIDTH-1:0] value_q;
  logic             carry_q, borrow_q, at_max_q;
  logic [WIDTH:0]   dmax, em, cur, nxt, lv;
  logic             co_n, bo_n;
  logic             up_prev, down_prev;
  logic             up_rise, down_rise;
  logic             step_up, step_dn;

  always_comb begin
    dmax = {1'b0, bus.dyn_max};
    em   = dmax;
    if (dmax < MINV)      em = MINV;
    else if (dmax > MAXV) em = MAXV;
  end

  assign up_rise   = bus.up   & ~up_prev;
  assign down_rise = bus.down & ~down_prev;

  // Previous-key registers reset to 1 so a key held through reset gives no step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_prev   <= 1'b1;
      down_prev <= 1'b1;
    end else begin
      up_prev   <= bus.up;
      down_prev <= bus.down;
    end
  end

`ifdef AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_t;
  localparam int TMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_DLY = TW'(REPEAT_DLY);
  localparam logic [TW-1:0] T_PER = TW'(REPEAT_PER);
  localparam logic [TW-1:0] T_ONE = TW'(1);

  rpt_t          st  [2];
  logic [TW-1:0] tmr [2];
  logic [1:0]    key, rise, step_k;
  logic          hold_ok;

  assign key     = {bus.down, bus.up};
  assign rise    = {down_rise, up_rise};
  // Both keys down, or leaving manual mode, aborts any repeat in progress.
  assign hold_ok = bus.manual_set & ~(&key);

  always_comb begin
    step_k = '0;
    for (int k = 0; k < 2; k++) begin
      if (hold_ok) begin
        case (st[k])
          IDLE:    step_k[k] = rise[k];
          DELAY:   step_k[k] = key[k] && (tmr[k] == T_DLY);
          REPEAT:  step_k[k] = key[k] && (tmr[k] == T_PER);
          default: step_k[k] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        st[k]  <= IDLE;
        tmr[k] <= '0;
      end else if (!key[k] || !hold_ok) begin
        st[k]  <= IDLE;
        tmr[k] <= '0;
      end else begin
        case (st[k])
          IDLE: if (rise[k]) begin
            st[k]  <= DELAY;
            tmr[k] <= T_ONE;
          end
          DELAY: if (tmr[k] == T_DLY) begin
            st[k]  <= REPEAT;
            tmr[k] <= T_ONE;
          end else begin
            tmr[k] <= tmr[k] + T_ONE;
          end
          REPEAT: tmr[k] <= (tmr[k] == T_PER) ? T_ONE : tmr[k] + T_ONE;
          default: begin
            st[k]  <= IDLE;
            tmr[k] <= '0;
          end
        endcase
      end
    end
  end

  assign step_up = step_k[0];
  assign step_dn = step_k[1];
`else
  assign step_up = up_rise & ~down_rise;
  assign step_dn = down_rise & ~up_rise;
`endif

  // A value above eff_max counts as "at eff_max" so carry still wraps and pulses.
  always_comb begin
    cur  = {1'b0, value_q};
    lv   = {1'b0, bus.load_val};
    nxt  = cur;
    co_n = 1'b0;
    bo_n = 1'b0;
    if (bus.load) begin
      if (lv < MINV)    nxt = MINV;
      else if (lv > em) nxt = em;
      else              nxt = lv;
    end else if (bus.manual_set && step_up) begin
      nxt = (cur >= em) ? MINV : cur + 1'b1;
    end else if (bus.manual_set && step_dn) begin
      nxt = (cur <= MINV) ? em : cur - 1'b1;
    end else if (!bus.manual_set && bus.carry_in && !bus.borrow_in) begin
      if (cur >= em) begin
        nxt  = MINV;
        co_n = 1'b1;
      end else begin
        nxt = cur + 1'b1;
      end
    end else if (!bus.manual_set && bus.borrow_in && !bus.carry_in) begin
      if (cur <= MINV) begin
        nxt  = em;
        bo_n = 1'b1;
      end else begin
        nxt = cur - 1'b1;
      end
    end else if (cur > em) begin
      nxt = em;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q  <= RSTV;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      at_max_q <= 1'b0;
    end else begin
      value_q  <= nxt[WIDTH-1:0];
      carry_q  <= co_n;
      borrow_q <= bo_n;
      at_max_q <= (nxt == em);
    end
  end

  assign bus.value      = value_q;
  assign bus.carry_out  = carry_q;
  assign bus.borrow_out = borrow_q;
  assign bus.at_max     = at_max_q;
endmodule
